// File: rtl/cnt_obi_to_reg_buf.sv
// -----------------------------------------------------------------------------
// cnt_obi_to_reg_buf
//
// Bridge from an OBI manager to a single-cycle register interface (counter
// peripheral and similar register files). Every granted OBI request is handed
// to the register interface in the same cycle. The register response is
// captured into a RSP_DEPTH-entry response FIFO, so the OBI manager may stall
// responses with obi_rready_i. Grant is withheld while the FIFO is full, so no
// response is ever dropped or duplicated, and responses leave in grant order.
//
// Optional feature (compile-time macro CNT_OBI_TO_REG_ERR_EN):
//   defined   : each FIFO entry also stores reg_error_i; obi_err_o shows the
//               head entry's error bit.
//   undefined : entries are DW bits wide, reg_error_i is ignored and obi_err_o
//               is constant 0.
//
// Handshakes:
//   OBI request : a request transfers in a cycle with obi_req_i & obi_gnt_o.
//                 The request fields must be held stable until granted.
//   Register    : a register access completes in a cycle with
//                 reg_valid_o & reg_ready_i; reg_rdata_i / reg_error_i are
//                 sampled in that cycle. Because grant requires reg_ready_i,
//                 OBI grant and register completion are the same event.
//   OBI response: a response transfers in a cycle with
//                 obi_rvalid_o & obi_rready_i. While obi_rvalid_o=1 and
//                 obi_rready_i=0 the response stays stable.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   obi_req_i ... obi_wdata_i, obi_gnt_o   OBI request channel
//   obi_rvalid_o, obi_rready_i, obi_rdata_o, obi_err_o   OBI response channel
//   reg_valid_o ... reg_wdata_o, reg_ready_i, reg_rdata_i, reg_error_i
//                         register interface
//   outstanding_o         response FIFO occupancy
// -----------------------------------------------------------------------------
module cnt_obi_to_reg_buf #(
  parameter  int unsigned AW        = 32,
  parameter  int unsigned DW        = 32,
  parameter  int unsigned RSP_DEPTH = 2,
  localparam int unsigned BEW       = DW / 8,
  localparam int unsigned CW        = $clog2(RSP_DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  // OBI request
  input  logic           obi_req_i,
  input  logic           obi_we_i,
  input  logic [BEW-1:0] obi_be_i,
  input  logic [AW-1:0]  obi_addr_i,
  input  logic [DW-1:0]  obi_wdata_i,
  output logic           obi_gnt_o,
  // OBI response
  output logic           obi_rvalid_o,
  input  logic           obi_rready_i,
  output logic [DW-1:0]  obi_rdata_o,
  output logic           obi_err_o,
  // register interface
  output logic           reg_valid_o,
  output logic           reg_write_o,
  output logic [BEW-1:0] reg_wstrb_o,
  output logic [AW-1:0]  reg_addr_o,
  output logic [DW-1:0]  reg_wdata_o,
  input  logic           reg_ready_i,
  input  logic [DW-1:0]  reg_rdata_i,
  input  logic           reg_error_i,
  // status
  output logic [CW-1:0]  outstanding_o
);

  // Pointer width; a depth of 1 still needs a 1-bit pointer.
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

`ifdef CNT_OBI_TO_REG_ERR_EN
  localparam int unsigned EW = DW + 1;
`else
  localparam int unsigned EW = DW;
`endif

  logic [EW-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          full;
  logic          push;
  logic          pop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;

  // Full depends only on registered state, so obi_rready_i can never reach
  // obi_gnt_o combinationally: a pop in a full cycle frees space only from
  // the next cycle on.
  assign full = (count_q == CW'(RSP_DEPTH));

  // Request path: register interface sees the OBI request directly.
  assign reg_valid_o = obi_req_i & ~full;
  assign reg_write_o = obi_we_i;
  assign reg_wstrb_o = obi_be_i;
  assign reg_addr_o  = obi_addr_i;
  assign reg_wdata_o = obi_wdata_i;

  assign obi_gnt_o   = obi_req_i & reg_ready_i & ~full;

  assign push = obi_gnt_o;
  assign pop  = obi_rvalid_o & obi_rready_i;

`ifdef CNT_OBI_TO_REG_ERR_EN
  assign push_entry = {reg_error_i, reg_rdata_i};
`else
  assign push_entry = reg_rdata_i;
  // reg_error_i has no use in this build.
  logic unused_reg_error;
  assign unused_reg_error = reg_error_i;
`endif

  // Explicit wrap compare so non-power-of-two depths work.
  assign wr_ptr_next = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
  assign rd_ptr_next = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

  // Storage is not reset: an entry is only observable while counted.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_next;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_next;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Response path: head entry, forced to zero while the FIFO is empty.
  assign head_entry    = mem_q[rd_ptr_q];
  assign obi_rvalid_o  = (count_q != '0);
  assign obi_rdata_o   = obi_rvalid_o ? head_entry[DW-1:0] : '0;
`ifdef CNT_OBI_TO_REG_ERR_EN
  assign obi_err_o     = obi_rvalid_o & head_entry[DW];
`else
  assign obi_err_o     = 1'b0;
`endif
  assign outstanding_o = count_q;

endmodule
